debounce_bank: RTL

Multi-channel push-button conditioner for the calculator keypad and front-panel switches. It replaces single-button debouncing with a bank of `NCH` independent channels. Each channel synchronises its raw input, debounces both press and release, and produces a level output, press and release pulses, and an optional typematic auto-repeat pulse. It sits between the board pins and the keypad decoder / calculator control FSM. All outputs are synchronous to `clk`.

---
 rtl/debounce_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Bank of independent push-button conditioners: 2-FF sync, press/release debounce,
// level output, press/release pulses and optional typematic auto-repeat per channel.

module debounce_chan #(
    parameter int CNT_W      = 15,
    parameter int REPEAT_EN  = 1,
    parameter int REP_W      = 24,
    parameter int REP_DELAY  = 12_500_000,
    parameter int REP_PERIOD = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_state,
    output logic pb_press,
    output logic pb_release,
    output logic pb_repeat
);
    typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, REL_CNT} state_t;

    localparam logic [REP_W-1:0] DLY_LIM = REP_W'(REP_DELAY);
    localparam logic [REP_W-1:0] PER_LIM = REP_W'(REP_PERIOD);

    logic             sync1, s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             rep_phase;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_lim;

    assign rep_inc = rep_cnt + 1'b1;
    assign rep_lim = rep_phase ? PER_LIM : DLY_LIM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= pb_in;
            s     <= sync1;
        end
    end

    // Outputs are assigned alongside the state transition that produces them,
    // so they reflect the next state on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rep_cnt    <= '0;
            rep_phase  <= 1'b0;
            pb_state   <= 1'b0;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            pb_repeat  <= 1'b0;
        end else begin
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            pb_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    rep_cnt   <= '0;
                    rep_phase <= 1'b0;
                    if (s) state <= PRESS_CNT;
                end
                PRESS_CNT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (&cnt) begin
                        state     <= HELD;
                        cnt       <= '0;
                        rep_cnt   <= '0;
                        rep_phase <= 1'b0;
                        pb_state  <= 1'b1;
                        pb_press  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (!s) state <= REL_CNT;
                    if (REPEAT_EN != 0) begin
                        if (rep_inc == rep_lim) begin
                            rep_cnt   <= '0;
                            rep_phase <= 1'b1;
                            pb_repeat <= 1'b1;
                        end else begin
                            rep_cnt <= rep_inc;
                        end
                    end
                end
                REL_CNT: begin
                    // repeat counter is frozen here so a glitch only delays repeats
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (&cnt) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        rep_cnt    <= '0;
                        rep_phase  <= 1'b0;
                        pb_state   <= 1'b0;
                        pb_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    pb_state <= 1'b0;
                end
            endcase
        end
    end
endmodule

module debounce_bank #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 15,
    parameter int REPEAT_EN  = 1,
    parameter int REP_W      = 24,
    parameter int REP_DELAY  = 12_500_000,
    parameter int REP_PERIOD = 2_500_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] pb_in,
    output logic [NCH-1:0] pb_state,
    output logic [NCH-1:0] pb_press,
    output logic [NCH-1:0] pb_release,
    output logic [NCH-1:0] pb_repeat
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_chan #(
            .CNT_W     (CNT_W),
            .REPEAT_EN (REPEAT_EN),
            .REP_W     (REP_W),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pb_in     (pb_in[i]),
            .pb_state  (pb_state[i]),
            .pb_press  (pb_press[i]),
            .pb_release(pb_release[i]),
            .pb_repeat (pb_repeat[i])
        );
    end
endmodule
